// File: rtl/sw_logic_pkg.sv
// Shared types and constants for the switch-to-LED logic unit.
package sw_logic_pkg;

  typedef enum logic [1:0] {
    MODE_AND = 2'b00,
    MODE_OR  = 2'b01,
    MODE_XOR = 2'b10,
    MODE_TOG = 2'b11
  } mode_t;

  localparam int EDGE_CNT_W = 8;

endpackage

// File: rtl/sw_debounce.sv
// One switch: 2-flop synchroniser followed by a stability-count debouncer.
module sw_debounce
  import sw_logic_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic clean_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_q;
  logic             clean_d;

  // Any disagreement that is not sustained for DEB_CYCLES samples restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (sync2_q == clean_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
      clean_d = sync2_q;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      clean_q <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean_o = clean_q;

endmodule

// File: rtl/sw_logic_gen.sv
// Debounced switches drive LEDs through AND/OR/XOR/toggle of adjacent pairs.
// Optional rise counter on switch 0 enabled by defining SWL_EDGE_CNT_EN.
module sw_logic_gen
  import sw_logic_pkg::*;
#(
  parameter int N_SW       = 4,
  parameter int N_LD       = 3,
  parameter int DEB_CYCLES = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_SW-1:0] SW,
  input  logic [1:0]      MODE,
  output logic [N_LD-1:0] LD,
`ifdef SWL_EDGE_CNT_EN
  output logic [EDGE_CNT_W-1:0] EDGE_CNT,
`endif
  output logic [N_SW-1:0] SW_CLEAN
);

  logic [N_SW-1:0] clean_s;
  logic [N_LD-1:0] prev_q;
  logic [N_LD-1:0] rise_s;
  logic [N_LD-1:0] tog_q;
  logic [N_LD-1:0] tog_d;
  logic [N_LD-1:0] ld_q;
  logic [N_LD-1:0] ld_d;
  logic [N_LD-1:0] a_s;
  logic [N_LD-1:0] b_s;

  for (genvar k = 0; k < N_SW; k++) begin : g_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_i   (CLK),
      .rst_i   (RST),
      .sw_i    (SW[k]),
      .clean_o (clean_s[k])
    );
  end

  assign a_s    = clean_s[N_LD-1:0];
  assign b_s    = clean_s[N_LD:1];
  assign rise_s = clean_s[N_LD-1:0] & ~prev_q;
  assign tog_d  = tog_q ^ rise_s;

  // LED function select; toggle mode shows the latch, which keeps running in every mode.
  always_comb begin
    ld_d = ld_q;
    case (mode_t'(MODE))
      MODE_AND: ld_d = a_s & b_s;
      MODE_OR:  ld_d = a_s | b_s;
      MODE_XOR: ld_d = a_s ^ b_s;
      MODE_TOG: ld_d = tog_q;
      default:  ld_d = ld_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q <= {N_LD{1'b0}};
      tog_q  <= {N_LD{1'b0}};
      ld_q   <= {N_LD{1'b0}};
    end else begin
      prev_q <= clean_s[N_LD-1:0];
      tog_q  <= tog_d;
      ld_q   <= ld_d;
    end
  end

`ifdef SWL_EDGE_CNT_EN
  logic [EDGE_CNT_W-1:0] ecnt_q;
  logic [EDGE_CNT_W-1:0] ecnt_d;

  // Saturating count of debounced rises on switch 0.
  always_comb begin
    ecnt_d = ecnt_q;
    if (rise_s[0] && (ecnt_q != {EDGE_CNT_W{1'b1}})) begin
      ecnt_d = ecnt_q + EDGE_CNT_W'(1);
    end else begin
      ecnt_d = ecnt_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ecnt_q <= {EDGE_CNT_W{1'b0}};
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign EDGE_CNT = ecnt_q;
`endif

  assign LD       = ld_q;
  assign SW_CLEAN = clean_s;

endmodule
